// File: rtl/ped_request.sv
// Pedestrian push-button front end: synchronizer, debouncer, seconds prescaler and request FSM.
// Define PED_COOLDOWN_EN to compile in the post-acknowledge cooldown state and its seconds counter.
module ped_request #(
  parameter int unsigned CLK_HZ          = 24000000,
  parameter int unsigned DEBOUNCE_CYCLES = 240000,
  parameter int unsigned COOLDOWN_S      = 30
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       btn_n,
  input  logic       ped_ack,
  output logic       ped_req,
  output logic       sec_tick,
  output logic       btn_level,
  output logic [7:0] press_cnt
);

  localparam int unsigned PRESC_W = (CLK_HZ > 1) ? $clog2(CLK_HZ) : 1;
  localparam int unsigned DB_W    = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
  localparam logic [PRESC_W-1:0] PRESC_LAST = PRESC_W'(CLK_HZ - 1);
  localparam logic [DB_W-1:0]    DB_LAST    = DB_W'(DEBOUNCE_CYCLES - 1);

`ifdef PED_COOLDOWN_EN
  // One extra value so the counter can actually hold COOLDOWN_S when the comparison fires.
  localparam int unsigned CD_W = (COOLDOWN_S > 0) ? $clog2(COOLDOWN_S + 1) : 1;
  localparam logic [CD_W-1:0] CD_DONE = CD_W'(COOLDOWN_S);

  typedef enum logic [1:0] {S_IDLE, S_REQ, S_COOLDOWN} state_t;
`else
  typedef enum logic {S_IDLE, S_REQ} state_t;
`endif

  state_t               state_q,       state_d;
  logic                 sync1_q,       sync1_d;
  logic                 sync2_q,       sync2_d;
  logic [DB_W-1:0]      db_cnt_q,      db_cnt_d;
  logic                 btn_level_q,   btn_level_d;
  logic                 level_prev_q,  level_prev_d;
  logic [PRESC_W-1:0]   presc_q,       presc_d;
  logic                 sec_tick_q,    sec_tick_d;
  logic [7:0]           press_cnt_q,   press_cnt_d;
`ifdef PED_COOLDOWN_EN
  logic [CD_W-1:0]      cd_cnt_q,      cd_cnt_d;
`endif

  logic press_level;
  logic press_evt;

  // NOTE: every combinational output gets a default first, so no path leaves it unassigned (no latch).
  always_comb begin
    sync1_d     = btn_n;
    sync2_d     = sync1_q;
    press_level = ~sync2_q;

    db_cnt_d    = db_cnt_q;
    btn_level_d = btn_level_q;
    if (press_level == btn_level_q) begin
      db_cnt_d = '0;
    end else if (db_cnt_q == DB_LAST) begin
      btn_level_d = press_level;
      db_cnt_d    = '0;
    end else begin
      db_cnt_d = db_cnt_q + DB_W'(1);
    end

    // Only the rising edge of the debounced level is a press; release is silent.
    level_prev_d = btn_level_q;
    press_evt    = btn_level_q & ~level_prev_q;

    presc_d    = (presc_q == PRESC_LAST) ? '0 : presc_q + PRESC_W'(1);
    sec_tick_d = (presc_d == PRESC_LAST);

    press_cnt_d = press_cnt_q;
    if (press_evt && (press_cnt_q != 8'hFF)) begin
      press_cnt_d = press_cnt_q + 8'd1;
    end
  end

  always_comb begin
    state_d = state_q;
`ifdef PED_COOLDOWN_EN
    cd_cnt_d = cd_cnt_q;
`endif
    case (state_q)
      S_IDLE: begin
        if (press_evt) state_d = S_REQ;
      end
      S_REQ: begin
        // A press landing together with the ack is already covered by this grant.
        if (ped_ack) begin
`ifdef PED_COOLDOWN_EN
          state_d  = S_COOLDOWN;
          cd_cnt_d = '0;
`else
          state_d = S_IDLE;
`endif
        end
      end
`ifdef PED_COOLDOWN_EN
      S_COOLDOWN: begin
        if (sec_tick_q) begin
          cd_cnt_d = cd_cnt_q + CD_W'(1);
          if (cd_cnt_d == CD_DONE) state_d = S_IDLE;
        end
      end
`endif
      default: state_d = S_IDLE;
    endcase
  end

  // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= S_IDLE;
      // NOTE: synchronizer resets to 1 (button released) so a held button must still debounce after reset.
      sync1_q      <= 1'b1;
      sync2_q      <= 1'b1;
      db_cnt_q     <= '0;
      btn_level_q  <= 1'b0;
      level_prev_q <= 1'b0;
      presc_q      <= '0;
      sec_tick_q   <= 1'b0;
      press_cnt_q  <= '0;
`ifdef PED_COOLDOWN_EN
      cd_cnt_q     <= '0;
`endif
    end else begin
      state_q      <= state_d;
      sync1_q      <= sync1_d;
      sync2_q      <= sync2_d;
      db_cnt_q     <= db_cnt_d;
      btn_level_q  <= btn_level_d;
      level_prev_q <= level_prev_d;
      presc_q      <= presc_d;
      sec_tick_q   <= sec_tick_d;
      press_cnt_q  <= press_cnt_d;
`ifdef PED_COOLDOWN_EN
      cd_cnt_q     <= cd_cnt_d;
`endif
    end
  end

  assign ped_req   = (state_q == S_REQ);
  assign sec_tick  = sec_tick_q;
  assign btn_level = btn_level_q;
  assign press_cnt = press_cnt_q;

endmodule

// File: tb/tb_ped_request.sv
// Bench for ped_request: directed vector table, press-count saturation run, and random
// stimulus against a run-length/arithmetic reference model (CLK_HZ=10, DEBOUNCE=4, COOLDOWN=2).
module tb_ped_request;

  localparam int CLK_HZ = 10;
  localparam int DB     = 4;
  localparam int CD_S   = 2;
`ifdef PED_COOLDOWN_EN
  localparam bit COOL_EN = 1'b1;
`else
  localparam bit COOL_EN = 1'b0;
`endif

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       btn_n = 1'b1;
  logic       ped_ack = 1'b0;
  logic       ped_req;
  logic       sec_tick;
  logic       btn_level;
  logic [7:0] press_cnt;

  ped_request #(
    .CLK_HZ          (CLK_HZ),
    .DEBOUNCE_CYCLES (DB),
    .COOLDOWN_S      (CD_S)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .btn_n     (btn_n),
    .ped_ack   (ped_ack),
    .ped_req   (ped_req),
    .sec_tick  (sec_tick),
    .btn_level (btn_level),
    .press_cnt (press_cnt)
  );

  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_bad = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Reference model: sync history array, run-length debounce, edge-count arithmetic for seconds,
  // and a pending flag plus seconds-remaining count for the request/cooldown behaviour.
  bit m_sync [2] = '{1'b1, 1'b1};
  bit m_level = 0, m_rose = 0, m_pending = 0, m_tick = 0;
  int m_streak = 0, m_cool = 0, m_cnt = 0, m_edges = 0;

  always @(posedge clk) begin
    bit press, sampled;
    if (rst) begin
      m_sync = '{1'b1, 1'b1};
      m_level = 0; m_rose = 0; m_pending = 0; m_tick = 0;
      m_streak = 0; m_cool = 0; m_cnt = 0; m_edges = 0;
    end else begin
      press = m_rose;
      if (m_pending) begin
        if (ped_ack) begin
          m_pending = 0;
          m_cool = COOL_EN ? CD_S : 0;
        end
      end else if (m_cool > 0) begin
        if (m_tick) m_cool--;
      end else if (press) begin
        m_pending = 1;
      end
      if (press && m_cnt < 255) m_cnt++;

      sampled = !m_sync[1];
      m_rose = 0;
      if (sampled != m_level) begin
        m_streak++;
        if (m_streak == DB) begin
          m_level = sampled;
          m_rose = sampled;
          m_streak = 0;
        end
      end else begin
        m_streak = 0;
      end
      m_sync[1] = m_sync[0];
      m_sync[0] = btn_n;

      m_edges++;
      m_tick = ((m_edges % CLK_HZ) == CLK_HZ - 1);
    end
  end

  typedef struct {
    string name;
    bit    rst;
    bit    btn_n;
    bit    ack;
    int    n;
    bit    e_req;
    bit    e_lvl;
    bit    e_tick;
    int    e_cnt;
  } vec_t;

  vec_t vq[$];

  function automatic void add(string name, bit r, bit b, bit a, int n,
                              bit e_req, bit e_lvl, bit e_tick, int e_cnt);
    vec_t v;
    v.name = name; v.rst = r; v.btn_n = b; v.ack = a; v.n = n;
    v.e_req = e_req; v.e_lvl = e_lvl; v.e_tick = e_tick; v.e_cnt = e_cnt;
    vq.push_back(v);
  endfunction

  initial begin
    int hold;

    //  name                      rst btn ack  n  req      lvl tick cnt
    add("reset",                   1,  1,  0,  2, 0,        0,  0,   0);
    add("press_sync_debounce",     0,  0,  0,  5, 0,        0,  0,   0);
    add("level_rise",              0,  0,  0,  1, 0,        1,  0,   0);
    add("req_rise",                0,  0,  0,  1, 1,        1,  0,   1);
    add("release_first_tick",      0,  1,  0,  2, 1,        1,  1,   1);
    add("release_no_event",        0,  1,  0,  5, 1,        0,  0,   1);
    add("ack_drops_req",           0,  1,  1,  1, 0,        0,  0,   1);
    add("after_ack_tick",          0,  1,  0,  4, 0,        0,  1,   1);
    add("press_after_ack",         0,  0,  0,  7, !COOL_EN, 1,  0,   2);
    add("cooldown_over",           0,  1,  0,  6, !COOL_EN, 0,  0,   2);
    add("press_after_cooldown",    0,  0,  0,  7, 1,        1,  1,   3);
    add("release_in_req",          0,  1,  0,  6, 1,        0,  0,   3);
    add("level_rise_in_req",       0,  0,  0,  6, 1,        1,  0,   3);
    add("ack_with_press",          0,  0,  1,  1, 0,        1,  0,   4);
    add("no_requeue",              0,  0,  0,  3, 0,        1,  0,   4);
    add("long_release",            0,  1,  0, 15, 0,        0,  0,   4);
    add("press_before_reset",      0,  0,  0,  7, 1,        1,  0,   5);
    add("reset_mid_req",           1,  0,  0,  1, 0,        0,  0,   0);
    add("held_through_reset",      0,  0,  0,  5, 0,        0,  0,   0);
    add("first_tick_after_reset",  0,  0,  0,  4, 1,        1,  1,   1);
    add("tick_one_cycle",          0,  0,  0,  1, 1,        1,  0,   1);
    add("ack_again",               0,  0,  1,  1, 0,        1,  0,   1);
    add("release_again",           0,  1,  0,  6, 0,        0,  0,   1);
    for (int k = 0; k < 10; k++) begin
      add("bounce", 0, k[0], 0, 2, 0, 0, ((19 + 2 * k) % CLK_HZ) == CLK_HZ - 1, 1);
    end
    add("bounce_settle",           0,  1,  0,  8, 0,        0,  0,   1);

    @(negedge clk);
    foreach (vq[i]) begin
      rst = vq[i].rst; btn_n = vq[i].btn_n; ped_ack = vq[i].ack;
      repeat (vq[i].n) @(negedge clk);
      check({vq[i].name, ".ped_req"},   32'(ped_req),   32'(vq[i].e_req));
      check({vq[i].name, ".btn_level"}, 32'(btn_level), 32'(vq[i].e_lvl));
      check({vq[i].name, ".sec_tick"},  32'(sec_tick),  32'(vq[i].e_tick));
      check({vq[i].name, ".press_cnt"}, 32'(press_cnt), 32'(vq[i].e_cnt));
    end

    // Saturation: 260 clean, acknowledged presses from a fresh reset.
    rst = 1; btn_n = 1; ped_ack = 0;
    @(negedge clk);
    rst = 0;
    for (int i = 1; i <= 260; i++) begin
      btn_n = 0;
      repeat (8) @(negedge clk);
      ped_ack = 1;
      @(negedge clk);
      ped_ack = 0; btn_n = 1;
      repeat (8) @(negedge clk);
      check("press_cnt_sat", 32'(press_cnt), (i > 255) ? 32'd255 : 32'(i));
    end

    // Random stimulus compared cycle by cycle with the model.
    hold = 0;
    for (int c = 0; c < 3000; c++) begin
      @(negedge clk);
      check("rand.ped_req",   32'(ped_req),   32'(m_pending));
      check("rand.btn_level", 32'(btn_level), 32'(m_level));
      check("rand.sec_tick",  32'(sec_tick),  32'(m_tick));
      check("rand.press_cnt", 32'(press_cnt), 32'(m_cnt));
      if (hold == 0) begin
        btn_n = $urandom_range(0, 1) == 1;
        hold  = $urandom_range(1, 12);
      end
      hold--;
      ped_ack = ($urandom_range(0, 5) == 0);
      rst     = ($urandom_range(0, 399) == 0);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/ped_request.md
PED_REQUEST -- requirements
Module: ped_request

Interface
REQ-001 Parameter CLK_HZ, default 24000000, clock cycles per second (sec_tick period).
REQ-002 Parameter DEBOUNCE_CYCLES, default 240000, cycles btn_n must hold a new level before acceptance (10 ms).
REQ-003 Parameter COOLDOWN_S, default 30, seconds after acknowledge during which presses are ignored.
REQ-004 clk  input  1  single system clock; all state updates on rising edge.
REQ-005 rst  input  1  reset, synchronous, active-high.
REQ-006 btn_n  input  1  raw pedestrian push-button, active-low, asynchronous to clk, bouncing.
REQ-007 ped_ack  input  1  from traffic light controller; 1-cycle pulse meaning the pedestrian phase has been granted.
REQ-008 ped_req  output  1  registered pedestrian request, held high until acknowledged.
REQ-009 sec_tick  output  1  registered 1-cycle pulse once per CLK_HZ cycles; shared seconds base for the controller.
REQ-010 btn_level  output  1  debounced button state, 1 = pressed.
REQ-011 press_cnt  output  8  count of accepted presses since reset, saturating.

Function
REQ-012 btn_n SHALL pass through a 2-flop synchronizer before any other use; its inverted output is the sampled press level.
REQ-013 Debounce counter SHALL clear whenever the sampled level equals btn_level, and SHALL increment otherwise; on reaching DEBOUNCE_CYCLES-1 while differing, btn_level SHALL take the sampled level next cycle and the counter SHALL clear.
REQ-014 An accepted press SHALL be a 0->1 transition of btn_level; 1->0 transitions SHALL produce no event.
REQ-015 Prescaler SHALL count 0..CLK_HZ-1 and wrap; sec_tick SHALL be 1 for exactly the cycle in which the count equals CLK_HZ-1, free-running regardless of FSM state.
REQ-016 FSM states: IDLE, REQ, COOLDOWN; ped_req SHALL be 1 exactly when state is REQ.
REQ-017 IDLE: accepted press -> REQ; ped_req SHALL rise the cycle after btn_level rises (1-cycle latency); ped_ack ignored.
REQ-018 REQ: ped_ack=1 -> COOLDOWN (or IDLE per REQ-027); further presses SHALL be merged into the pending request.
REQ-019 Press and ped_ack in the same REQ cycle: ack SHALL win, press SHALL be merged, not re-queued.
REQ-020 COOLDOWN: cooldown counter SHALL clear on entry, increment on each sec_tick, and on the sec_tick that makes it equal COOLDOWN_S the FSM SHALL return to IDLE; presses and ped_ack ignored.
REQ-021 press_cnt SHALL increment on every accepted press in any state, and SHALL hold at 255.
REQ-022 All counters SHALL be sized by $clog2 of their parameter bound; no truncation of the terminal comparisons.

Reset
REQ-023 rst=1 at a clock edge SHALL force: state IDLE, ped_req=0, sec_tick=0, btn_level=0, press_cnt=0, synchronizer flops=1 (released), prescaler, debounce and cooldown counters=0.
REQ-024 Reset asserted mid-request or mid-cooldown SHALL discard the pending request/cooldown without emitting ped_req.
REQ-025 A button held low through reset release SHALL be accepted as a press only after DEBOUNCE_CYCLES of stable low following release.

Configuration
REQ-026 Macro PED_COOLDOWN_EN: when defined, COOLDOWN state and cooldown counter SHALL be compiled in, per REQ-020.
REQ-027 Without PED_COOLDOWN_EN: COOLDOWN state and cooldown counter SHALL be absent; REQ with ped_ack SHALL go directly to IDLE, so a press in the cycle after ack raises ped_req again; COOLDOWN_S unused.

Verification (CLK_HZ=10, DEBOUNCE_CYCLES=4, COOLDOWN_S=2)
REQ-028 Clean press: btn_n low for 10 cycles -> btn_level=1 after 2 sync + 4 debounce cycles, ped_req=1 one cycle later, press_cnt=1.
REQ-029 Bounce: btn_n toggles every 2 cycles for 20 cycles then high -> btn_level stays 0, ped_req stays 0, press_cnt=0.
REQ-030 Handshake: with ped_req=1, pulse ped_ack one cycle -> ped_req=0 next cycle; press 5 cycles later (macro on) -> no ped_req until 2 sec_ticks (20 cycles) elapsed; macro off -> ped_req=1 again.
REQ-031 Simultaneous: press accepted in the same cycle as ped_ack in REQ -> ped_req=0, press_cnt incremented, no new request.
REQ-032 Reset mid-operation: rst=1 for one cycle while ped_req=1 and press_cnt=3 -> ped_req=0, press_cnt=0, sec_tick restarts with first pulse 10 cycles after release.
REQ-033 Saturation: 260 clean presses, each acknowledged -> press_cnt=255, no wrap to 0.
